// File: rtl/traffic_light_monitor_if.sv
// Light inputs and checker results shared between a traffic light controller
// environment and the traffic_light_monitor.
interface traffic_light_monitor_if #(
   parameter int unsigned CNT_W = 8
);
   logic             enable;
   logic             clear;
   logic             red;
   logic             yellow;
   logic             green;
   logic             err_pulse;
   logic             err_sticky;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] cycle_count;
   logic [2:0]       phase;

   // Environment side: drives lights and controls, observes results
   modport master (
      output enable, clear, red, yellow, green,
      input  err_pulse, err_sticky, err_code, cycle_count, phase
   );

   // Monitor side
   modport slave (
      input  enable, clear, red, yellow, green,
      output err_pulse, err_sticky, err_code, cycle_count, phase
   );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for a RED -> GREEN -> YELLOW -> RED traffic light sequence.
// Flags one-hot, ordering and phase-duration violations and counts completed
// light cycles. All outputs are registered.
module traffic_light_monitor #(
   parameter int unsigned RED_LEN    = 3,
   parameter int unsigned GREEN_LEN  = 5,
   parameter int unsigned YELLOW_LEN = 2,
   parameter int unsigned CNT_W      = 8
) (
   input logic                              clk,
   input logic                              rstn,
   traffic_light_monitor_if.slave           mon
);

   localparam int unsigned MaxLen = (RED_LEN > GREEN_LEN) ?
                                    ((RED_LEN > YELLOW_LEN) ? RED_LEN : YELLOW_LEN) :
                                    ((GREEN_LEN > YELLOW_LEN) ? GREEN_LEN : YELLOW_LEN);
   // Counter must hold MaxLen + 1
   localparam int unsigned NW = $clog2(MaxLen + 2);

   localparam logic [1:0] CodeOnehot   = 2'd1;
   localparam logic [1:0] CodeOrder    = 2'd2;
   localparam logic [1:0] CodeDuration = 2'd3;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StRed    = 3'd1,
      StGreen  = 3'd2,
      StYellow = 3'd3,
      StSync   = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [NW-1:0]    n_q, n_d;
   logic             prev_red_q;
   logic             err_pulse_q;
   logic             err_sticky_q;
   logic [1:0]       err_code_q;
   logic [CNT_W-1:0] cycle_count_q;

   logic             lights_off, multi, red_only, yellow_only, green_only;
   logic             own_on, succ_on;
   logic [NW-1:0]    own_len;
   state_e           succ_state;
   logic             err_any;
   logic [1:0]       err_code_d;
   logic             cyc_inc;

   assign lights_off  = ~(mon.red | mon.yellow | mon.green);
   assign multi       = (mon.red & mon.yellow) | (mon.red & mon.green) |
                        (mon.yellow & mon.green);
   assign red_only    = mon.red & ~mon.yellow & ~mon.green;
   assign yellow_only = mon.yellow & ~mon.red & ~mon.green;
   assign green_only  = mon.green & ~mon.red & ~mon.yellow;

   // Next-state, phase counter and violation classification for one sample
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      err_any    = 1'b0;
      err_code_d = 2'd0;
      cyc_inc    = 1'b0;
      own_on     = 1'b0;
      succ_on    = 1'b0;
      own_len    = '0;
      succ_state = StIdle;

      unique case (state_q)
         StRed: begin
            own_on     = red_only;
            succ_on    = green_only;
            own_len    = NW'(RED_LEN);
            succ_state = StGreen;
         end
         StGreen: begin
            own_on     = green_only;
            succ_on    = yellow_only;
            own_len    = NW'(GREEN_LEN);
            succ_state = StYellow;
         end
         StYellow: begin
            own_on     = yellow_only;
            succ_on    = red_only;
            own_len    = NW'(YELLOW_LEN);
            succ_state = StRed;
         end
         default: ;
      endcase

      if (multi) begin
         // One-hot violation overrides every other check, in any state
         err_any    = 1'b1;
         err_code_d = CodeOnehot;
         state_d    = StSync;
         n_d        = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (red_only) begin
                  state_d = StRed;
                  n_d     = NW'(1);
               end else if (!lights_off) begin
                  err_any    = 1'b1;
                  err_code_d = CodeOrder;
                  state_d    = StSync;
                  n_d        = '0;
               end
            end
            StSync: begin
               if (lights_off) begin
                  state_d = StIdle;
                  n_d     = '0;
               end else if (red_only && !prev_red_q) begin
                  // Only a fresh rising red re-aligns the tracker
                  state_d = StRed;
                  n_d     = NW'(1);
               end
            end
            StRed, StGreen, StYellow: begin
               if (lights_off) begin
                  // Controller stopped: not a violation
                  state_d = StIdle;
                  n_d     = '0;
               end else if (own_on) begin
                  if (n_q == own_len) begin
                     err_any    = 1'b1;
                     err_code_d = CodeDuration;
                     state_d    = StSync;
                     n_d        = '0;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else if (succ_on) begin
                  if (n_q == own_len) begin
                     state_d = succ_state;
                     n_d     = NW'(1);
                     cyc_inc = (state_q == StYellow);
                  end else begin
                     err_any    = 1'b1;
                     err_code_d = CodeDuration;
                     state_d    = StSync;
                     n_d        = '0;
                  end
               end else begin
                  err_any    = 1'b1;
                  err_code_d = CodeOrder;
                  state_d    = StSync;
                  n_d        = '0;
               end
            end
            default: begin
               state_d = StIdle;
               n_d     = '0;
            end
         endcase
      end
   end

   // Tracker state only advances on enabled samples
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         n_q        <= '0;
         prev_red_q <= 1'b0;
      end else if (mon.enable) begin
         state_q    <= state_d;
         n_q        <= n_d;
         prev_red_q <= mon.red;
      end
   end

   // Error pulse, sticky flag and first-error code; clear beats a coincident error
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_pulse_q  <= 1'b0;
         err_sticky_q <= 1'b0;
         err_code_q   <= 2'd0;
      end else begin
         err_pulse_q <= mon.enable & err_any;
         if (mon.clear) begin
            err_sticky_q <= 1'b0;
            err_code_q   <= 2'd0;
         end else if (mon.enable && err_any && !err_sticky_q) begin
            err_sticky_q <= 1'b1;
            err_code_q   <= err_code_d;
         end
      end
   end

   // Saturating count of completed RED-GREEN-YELLOW cycles
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycle_count_q <= '0;
      end else if (mon.clear) begin
         cycle_count_q <= '0;
      end else if (mon.enable && cyc_inc && (cycle_count_q != '1)) begin
         cycle_count_q <= cycle_count_q + CNT_W'(1);
      end
   end

   assign mon.err_pulse   = err_pulse_q;
   assign mon.err_sticky  = err_sticky_q;
   assign mon.err_code    = err_code_q;
   assign mon.cycle_count = cycle_count_q;
   assign mon.phase       = state_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed table-driven bench for traffic_light_monitor (R3/G5/Y2, 8-bit count).
module tb_traffic_light_monitor;

   localparam logic [2:0] PI = 3'd0, PR = 3'd1, PG = 3'd2, PY = 3'd3, PS = 3'd4;

   typedef struct packed {
      logic       r, y, g, en, clr;
      logic       p, s;
      logic [1:0] code;
      logic [7:0] cnt;
      logic [2:0] ph;
   } vec_t;

   logic clk;
   logic rstn;
   int   n_cmp;
   int   n_err;
   vec_t vecs[$];

   traffic_light_monitor_if #(.CNT_W(8)) bus ();

   traffic_light_monitor #(
      .RED_LEN    (3),
      .GREEN_LEN  (5),
      .YELLOW_LEN (2),
      .CNT_W      (8)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .mon  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, y, g, en, clr, p, s, input logic [1:0] code,
                      input logic [7:0] cnt, input logic [2:0] ph);
      vec_t v;
      v = '{r: r, y: y, g: g, en: en, clr: clr, p: p, s: s, code: code, cnt: cnt, ph: ph};
      vecs.push_back(v);
   endtask

   // One legal R3 G5 Y2 phase sequence with constant flags/count
   task automatic cycle_rows(input logic [7:0] c, input logic s, input logic [1:0] code);
      for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 0, 0, s, code, c, PR);
      for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 0, 0, s, code, c, PG);
      for (int i = 0; i < 2; i++) add(0, 1, 0, 1, 0, 0, s, code, c, PY);
   endtask

   task automatic drive(input logic r, y, g, en, clr);
      bus.red    = r;
      bus.yellow = y;
      bus.green  = g;
      bus.enable = en;
      bus.clear  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic p, s, input logic [1:0] code,
                        input logic [7:0] cnt, input logic [2:0] ph);
      n_cmp++;
      if ({bus.err_pulse, bus.err_sticky, bus.err_code, bus.cycle_count, bus.phase} !==
          {p, s, code, cnt, ph}) begin
         n_err++;
         $display("FAIL %s: got pulse=%0b sticky=%0b code=%0d count=%0d phase=%0d, want pulse=%0b sticky=%0b code=%0d count=%0d phase=%0d",
                  name, bus.err_pulse, bus.err_sticky, bus.err_code, bus.cycle_count,
                  bus.phase, p, s, code, cnt, ph);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rstn  = 1'b0;
      bus.red = 0; bus.yellow = 0; bus.green = 0; bus.enable = 1; bus.clear = 0;
      #12;
      check("reset", 0, 0, 2'd0, 8'd0, PI);
      rstn = 1'b1;

      // Three legal cycles then red -> count 3
      cycle_rows(8'd0, 0, 2'd0);
      cycle_rows(8'd1, 0, 2'd0);
      cycle_rows(8'd2, 0, 2'd0);
      add(1, 0, 0, 1, 0, 0, 0, 2'd0, 8'd3, PR);
      // R3 G4 Y -> too-short green
      add(1, 0, 0, 1, 0, 0, 0, 2'd0, 8'd3, PR);
      add(1, 0, 0, 1, 0, 0, 0, 2'd0, 8'd3, PR);
      for (int i = 0; i < 4; i++) add(0, 0, 1, 1, 0, 0, 0, 2'd0, 8'd3, PG);
      add(0, 1, 0, 1, 0, 1, 1, 2'd3, 8'd3, PS);
      add(0, 0, 0, 1, 0, 0, 1, 2'd3, 8'd3, PI);
      add(0, 0, 0, 1, 1, 0, 0, 2'd0, 8'd0, PI);
      // R4 -> too-long red, then resync through OFF
      for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 0, 0, 0, 2'd0, 8'd0, PR);
      add(1, 0, 0, 1, 0, 1, 1, 2'd3, 8'd0, PS);
      add(0, 0, 0, 1, 0, 0, 1, 2'd3, 8'd0, PI);
      cycle_rows(8'd0, 1, 2'd3);
      add(1, 0, 0, 1, 0, 0, 1, 2'd3, 8'd1, PR);
      // Clear while running; then multi mid-GREEN
      add(1, 0, 0, 1, 1, 0, 0, 2'd0, 8'd0, PR);
      add(1, 0, 0, 1, 0, 0, 0, 2'd0, 8'd0, PR);
      for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 0, 0, 0, 2'd0, 8'd0, PG);
      add(1, 0, 1, 1, 0, 1, 1, 2'd1, 8'd0, PS);
      add(1, 0, 1, 1, 0, 1, 1, 2'd1, 8'd0, PS);
      add(1, 0, 1, 0, 0, 0, 1, 2'd1, 8'd0, PS);   // disabled: no pulse
      add(1, 0, 0, 1, 0, 0, 1, 2'd1, 8'd0, PS);   // previous sample had red
      add(0, 0, 1, 1, 0, 0, 1, 2'd1, 8'd0, PS);
      add(1, 0, 0, 1, 0, 0, 1, 2'd1, 8'd0, PR);
      add(0, 1, 0, 1, 0, 1, 1, 2'd1, 8'd0, PS);   // order error, code stays 1
      add(0, 0, 0, 1, 0, 0, 1, 2'd1, 8'd0, PI);
      add(0, 0, 0, 1, 1, 0, 0, 2'd0, 8'd0, PI);
      // Green from IDLE -> order error; clear
      add(0, 0, 1, 1, 0, 1, 1, 2'd2, 8'd0, PS);
      add(0, 0, 0, 1, 1, 0, 0, 2'd0, 8'd0, PI);
      // Error on the same edge as clear
      add(0, 0, 1, 1, 1, 1, 0, 2'd0, 8'd0, PS);
      add(0, 0, 0, 1, 0, 0, 0, 2'd0, 8'd0, PI);
      // Enable low freezes the red counter; then green too long
      add(1, 0, 0, 1, 0, 0, 0, 2'd0, 8'd0, PR);
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0, PR);
      add(1, 0, 0, 1, 0, 0, 0, 2'd0, 8'd0, PR);
      add(1, 0, 0, 1, 0, 0, 0, 2'd0, 8'd0, PR);
      for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 0, 0, 0, 2'd0, 8'd0, PG);
      add(0, 0, 1, 1, 0, 1, 1, 2'd3, 8'd0, PS);
      add(0, 0, 0, 1, 0, 0, 1, 2'd3, 8'd0, PI);

      foreach (vecs[i]) begin
         drive(vecs[i].r, vecs[i].y, vecs[i].g, vecs[i].en, vecs[i].clr);
         check($sformatf("vec%0d", i), vecs[i].p, vecs[i].s, vecs[i].code, vecs[i].cnt,
               vecs[i].ph);
      end

      // Counter saturation
      #2 rstn = 1'b0;
      #1 rstn = 1'b1;
      drive(1, 0, 0, 1, 0);
      for (int k = 1; k <= 256; k++) begin
         drive(1, 0, 0, 1, 0);
         drive(1, 0, 0, 1, 0);
         for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 0);
         drive(0, 1, 0, 1, 0);
         drive(0, 1, 0, 1, 0);
         drive(1, 0, 0, 1, 0);
         if (k == 255) check("count_255", 0, 0, 2'd0, 8'd255, PR);
      end
      check("count_sat", 0, 0, 2'd0, 8'd255, PR);

      // Reset mid-GREEN
      drive(1, 0, 0, 1, 0);
      drive(1, 0, 0, 1, 0);
      drive(0, 0, 1, 1, 0);
      drive(0, 0, 1, 1, 0);
      check("mid_green", 0, 0, 2'd0, 8'd255, PG);
      #2 rstn = 1'b0;
      #1;
      check("async_reset", 0, 0, 2'd0, 8'd0, PI);
      drive(0, 0, 1, 1, 0);
      rstn = 1'b1;
      drive(0, 0, 0, 1, 0);
      check("after_reset", 0, 0, 2'd0, 8'd0, PI);
      drive(1, 0, 0, 1, 0);
      check("restart_red", 0, 0, 2'd0, 8'd0, PR);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
